fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences the 9-bit instruction memory: drives current_pc, captures the returned
//  instruction into a fetch register, and handles start, stall, branch redirect, halt and out-of-range faults.
//  Sits between the instruction memory (combinational read, index = current_pc[11:0]) and decode/execute.
// PARAMETERS
//  IMEM_DEPTH  4096         instruction slots; legal PC range 0..IMEM_DEPTH-1 (power of two)
//  HALT_INSN   9'h1FF       encoding that stops fetch when it reaches the fetch register
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  start          in   1   one-cycle pulse; begins (or restarts) execution at PC 0
//  stall          in   1   downstream hold; freezes PC and fetch register
//  branch_taken   in   1   redirect for the instruction currently in the fetch register
//  branch_target  in   32  absolute target PC
//  instruction    in   9   instruction memory read data for current_pc
//  current_pc     out  32  PC driven to instruction memory
//  instr_out      out  9   fetch-register instruction
//  instr_pc       out  32  PC of instr_out
//  instr_valid    out  1   instr_out is a real instruction this cycle
//  done           out  1   high while HALTED after HALT_INSN retires
//  fault          out  1   sticky; PC left legal range
//  fetch_count    out  32  instructions captured since start, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  - Reset: state IDLE, current_pc=0, instr_out=0, instr_pc=0, instr_valid=0, done=0, fault=0, fetch_count=0.
//    Reset mid-operation has same effect; in-flight instruction discarded.
//  - States: IDLE --start--> RUN; RUN --halt/fault--> HALTED; HALTED --start--> RUN. start ignored in RUN.
//  - Entering RUN on start: current_pc<=0, instr_valid<=0, done<=0, fault<=0, fetch_count<=0.
//  - RUN, stall=1: all registers hold; branch_taken ignored (downstream holds it until stall drops).
//  - RUN, stall=0, priority top-down, evaluated on registered fetch stage:
//    1. instr_valid && instr_out==HALT_INSN: -> HALTED, done<=1, instr_valid<=0; branch ignored.
//    2. instr_valid && branch_taken: target >= IMEM_DEPTH -> HALTED, fault<=1, instr_valid<=0;
//       else current_pc<=branch_target, instr_valid<=0 (one bubble; wrong-path fetch flushed).
//    3. otherwise: instr_out<=instruction, instr_pc<=current_pc, instr_valid<=1, fetch_count+=1 (sat),
//       current_pc<=current_pc+1; if current_pc==IMEM_DEPTH-1 the increment instead sets fault<=1,
//       state HALTED, current_pc held; the captured last instruction is still marked valid for one cycle.
//  - branch_taken with instr_valid=0 is ignored in all states.
//  - Latency: PC to instr_valid 1 cycle; start to first instr_valid 2 cycles; taken branch to target valid 2 cycles.
//  - IDLE/HALTED: current_pc, instr_out, instr_pc, fetch_count hold; instr_valid=0 after the transition cycle.
//  - current_pc always < IMEM_DEPTH; upper bits zero.
// STRUCTURE
//  - fetch_pkg: typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t; localparam INSN_W=9, PC_W=32,
//    default HALT_INSN and IMEM_DEPTH values shared with instruction_memory and decode.
//  - Single module; no sub-module needed (next-PC mux + fetch register + saturating counter inline).
// TESTING
//  1. reset, start pulse, no stall -> current_pc 0,1,2..; instr_valid rises cycle 2; instr_pc lags current_pc by 1.
//  2. stall high 3 cycles at PC 5 -> current_pc=5, instr_out, fetch_count unchanged all 3 cycles; resumes at 6.
//  3. branch_taken, target 0x40 while instr_pc=7 -> one cycle instr_valid=0, next valid instr_pc=0x40.
//  4. HALT_INSN at PC 3 -> done=1 two cycles after PC 3 fetched, instr_valid=0, fetch_count=4; start -> PC 0, done=0.
//  5. branch to 4096 -> fault=1, HALTED; linear run to PC 4095 -> last instr valid, then fault=1, current_pc=4095.
//  6. reset asserted mid-run with stall and branch_taken high -> all outputs at reset values next cycle, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch stage. Instruction memory and decode use
//   the same instruction width, PC width, default memory depth and halt
//   encoding.
//   Contents:
//     INSN_W, PC_W                 instruction and program-counter widths
//     DEFAULT_IMEM_DEPTH           instruction slots (legal PC 0..depth-1)
//     DEFAULT_HALT_INSN            encoding that stops fetch when it retires
//     fetch_state_t                sequencer FSM states
//     sat_inc()                    saturating +1 for PC_W-wide counters
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int INSN_W = 9;
   localparam int PC_W   = 32;

   localparam int unsigned       DEFAULT_IMEM_DEPTH = 4096;
   localparam logic [INSN_W-1:0] DEFAULT_HALT_INSN  = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // Increment that sticks at all-ones instead of wrapping back to zero.
   function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] v);
      return (v == {PC_W{1'b1}}) ? v : v + PC_W'(1);
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the program counter. Drives current_pc to a combinational instruction
//   memory, captures the returned word into a one-entry fetch register, and
//   handles start, stall, branch redirect, halt and out-of-range faults.
//
//   Ports
//     clk            in   1   clock, all state on the rising edge
//     reset          in   1   synchronous, active-high
//     start          in   1   pulse; (re)starts execution at PC 0 from IDLE/HALTED
//     stall          in   1   downstream hold; freezes PC and fetch register
//     branch_taken   in   1   redirect for the instruction in the fetch register
//     branch_target  in  32   absolute target PC
//     instruction    in   9   memory read data for current_pc
//     current_pc     out 32   PC presented to instruction memory
//     instr_out      out  9   fetch-register instruction
//     instr_pc       out 32   PC of instr_out
//     instr_valid    out  1   instr_out holds a real instruction this cycle
//     done           out  1   high while halted after HALT_INSN retired
//     fault          out  1   sticky until next start; PC left the legal range
//     fetch_count    out 32   instructions captured since start (saturating)
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned       IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
   parameter logic [INSN_W-1:0] HALT_INSN  = DEFAULT_HALT_INSN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [PC_W-1:0]   branch_target,
   input  logic [INSN_W-1:0] instruction,
   output logic [PC_W-1:0]   current_pc,
   output logic [INSN_W-1:0] instr_out,
   output logic [PC_W-1:0]   instr_pc,
   output logic              instr_valid,
   output logic              done,
   output logic              fault,
   output logic [PC_W-1:0]   fetch_count
);

   localparam logic [PC_W-1:0] PC_LAST  = PC_W'(IMEM_DEPTH - 1);
   localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(IMEM_DEPTH);

   fetch_state_t      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [INSN_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]   ipc_q, ipc_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              fault_q, fault_d;
   logic [PC_W-1:0]   count_q, count_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      done_d  = done_q;
      fault_d = fault_q;
      count_d = count_q;

      case (state_q)
         RUN: begin
            // A stall freezes everything; a branch presented during the stall
            // is held by downstream and acted on once the stall drops.
            if (!stall) begin
               if (valid_q && (instr_q == HALT_INSN)) begin
                  // Halt wins over any branch request for the same slot.
                  state_d = HALTED;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
               end else if (valid_q && branch_taken) begin
                  // The word fetched this cycle is wrong-path: drop it and
                  // leave a single bubble while the target is fetched.
                  valid_d = 1'b0;
                  if (branch_target >= PC_LIMIT) begin
                     state_d = HALTED;
                     fault_d = 1'b1;
                  end else begin
                     pc_d = branch_target;
                  end
               end else begin
                  instr_d = instruction;
                  ipc_d   = pc_q;
                  valid_d = 1'b1;
                  count_d = sat_inc(count_q);
                  // Running off the end of memory: the last word is still
                  // delivered, but the PC never leaves the legal range.
                  if (pc_q == PC_LAST) begin
                     fault_d = 1'b1;
                     state_d = HALTED;
                  end else begin
                     pc_d = pc_q + PC_W'(1);
                  end
               end
            end
         end

         IDLE, HALTED: begin
            valid_d = 1'b0;
            if (start) begin
               state_d = RUN;
               pc_d    = '0;
               done_d  = 1'b0;
               fault_d = 1'b0;
               count_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

   assign current_pc  = pc_q;
   assign instr_out   = instr_q;
   assign instr_pc    = ipc_q;
   assign instr_valid = valid_q;
   assign done        = done_q;
   assign fault       = fault_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Random programs are loaded into a behavioural instruction memory. A
//   reference walk of each program (halt / branch / end-of-memory rules) pushes
//   the expected retired (pc, instruction) stream into a queue; a monitor pops
//   it whenever the DUT hands an instruction downstream. Branch requests come
//   from a tiny decode of the fetch register; random stall, spurious branch and
//   spurious start noise must not change the retired stream.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int          DEPTH = 4096;
   localparam logic [8:0]  HALT  = 9'h1FF;
   localparam int          MAX_CYCLES = 20000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [8:0]  instruction;
   logic [31:0] current_pc;
   logic [8:0]  instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        done;
   logic        fault;
   logic [31:0] fetch_count;

   logic [8:0]  mem [DEPTH];
   logic [31:0] tgt [DEPTH];

   logic        force_br = 1'b0;
   logic        rnd_br   = 1'b0;
   logic [31:0] rnd_tgt  = 32'h0;
   bit          stall_en = 1'b1;

   typedef struct {
      logic [31:0] pc;
      logic [8:0]  insn;
   } exp_t;
   exp_t exp_q [$];

   int pass_cnt  = 0;
   int total_cnt = 0;

   fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instruction   (instruction),
      .current_pc    (current_pc),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .done          (done),
      .fault         (fault),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory.
   assign instruction = mem[current_pc[11:0]];

   function automatic bit is_br(input logic [8:0] w);
      return w[8:6] == 3'b101;
   endfunction

   function automatic logic [8:0] plain_insn();
      logic [8:0] w;
      do w = 9'($urandom); while (is_br(w) || w == HALT);
      return w;
   endfunction

   // Decode of the fetch register: real branches redirect; spurious requests
   // are raised on invalid slots and on halts, where they must be ignored.
   always_comb begin
      branch_taken  = force_br;
      branch_target = rnd_tgt;
      if (instr_valid) begin
         if (is_br(instr_out)) begin
            branch_taken  = 1'b1;
            branch_target = tgt[instr_pc[11:0]];
         end else if (instr_out == HALT) begin
            branch_taken = branch_taken | rnd_br;
         end
      end else begin
         branch_taken = branch_taken | rnd_br;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- program builders ----------------
   task automatic fill_plain();
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = plain_insn();
         tgt[i] = $urandom;
      end
   endtask

   task automatic prog_branch(input int bpc, input logic [31:0] target, input int hpc);
      fill_plain();
      mem[bpc] = {3'b101, 6'($urandom)};
      tgt[bpc] = target;
      if (hpc >= 0) mem[hpc] = HALT;
   endtask

   task automatic prog_random();
      int h;
      fill_plain();
      h = $urandom_range(100, 300);
      mem[h] = HALT;
      for (int i = 0; i < h; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            mem[i] = {3'b101, 6'($urandom)};
            if ($urandom_range(0, 19) == 0) tgt[i] = 32'(DEPTH) + $urandom_range(0, 1000);
            else                            tgt[i] = $urandom_range(i + 1, h);
         end
      end
   endtask

   // Reference walk: the retired stream of the current program.
   task automatic build_trace(output int n, output bit efault, output logic [31:0] end_pc);
      int unsigned pc;
      exp_t e;
      pc = 0; n = 0; efault = 1'b0; end_pc = 32'h0;
      forever begin
         e.pc = 32'(pc);
         e.insn = mem[pc];
         exp_q.push_back(e);
         n++;
         if (pc == DEPTH - 1) begin efault = 1'b1; end_pc = 32'(pc); break; end
         if (mem[pc] == HALT) begin end_pc = 32'(pc + 1); break; end
         if (is_br(mem[pc])) begin
            if (tgt[pc] >= 32'(DEPTH)) begin efault = 1'b1; end_pc = 32'(pc + 1); break; end
            pc = tgt[pc];
         end else begin
            pc++;
         end
         if (n > 3 * DEPTH) break;
      end
   endtask

   // ---------------- run one program ----------------
   task automatic run_program(input string tag, input bit lat_chk, input int abort_after);
      int n, cycles;
      bit efault;
      logic [31:0] end_pc;
      build_trace(n, efault, end_pc);

      @(negedge clk); #1;
      start = 1'b1; stall = 1'b0;
      @(negedge clk);
      check({tag, "_start_pc"},    current_pc,  32'h0);
      check({tag, "_start_valid"}, instr_valid, 32'h0);
      check({tag, "_start_done"},  done,        32'h0);
      check({tag, "_start_fault"}, fault,       32'h0);
      check({tag, "_start_count"}, fetch_count, 32'h0);
      #1;
      start = 1'b0; stall = 1'b0;
      if (lat_chk) begin
         @(negedge clk);
         check({tag, "_lat_valid"}, instr_valid, 32'h1);
         check({tag, "_lat_ipc"},   instr_pc,    32'h0);
         check({tag, "_lat_pc"},    current_pc,  32'h1);
         #1;
      end

      cycles = 0;
      forever begin
         stall   = stall_en && ($urandom_range(0, 3) == 0);
         rnd_br  = 1'($urandom);
         rnd_tgt = $urandom;
         start   = !done && !fault && ($urandom_range(0, 15) == 0);
         @(negedge clk);
         cycles++;
         if ((done || fault) && !instr_valid) break;
         if (abort_after != 0 && cycles == abort_after) break;
         if (cycles > MAX_CYCLES) break;
         #1;
      end
      start = 1'b0;
      stall = 1'b0;

      if (cycles > MAX_CYCLES) begin
         total_cnt++;
         $display("FAIL %s_timeout: got no halt/fault after %0d cycles, expected within %0d", tag, cycles, MAX_CYCLES);
         reset = 1'b1;
         @(negedge clk); #1;
         reset = 1'b0;
         exp_q.delete();
         return;
      end

      if (abort_after != 0) begin
         // Reset in the middle of a run with stall and a branch request high.
         #1;
         reset = 1'b1; stall = 1'b1; force_br = 1'b1;
         exp_q.delete();
         @(negedge clk);
         check({tag, "_rst_pc"},    current_pc,  32'h0);
         check({tag, "_rst_insn"},  instr_out,   32'h0);
         check({tag, "_rst_ipc"},   instr_pc,    32'h0);
         check({tag, "_rst_valid"}, instr_valid, 32'h0);
         check({tag, "_rst_done"},  done,        32'h0);
         check({tag, "_rst_fault"}, fault,       32'h0);
         check({tag, "_rst_count"}, fetch_count, 32'h0);
         #1;
         reset = 1'b0; stall = 1'b0; force_br = 1'b0;
         repeat (3) @(negedge clk);
         check({tag, "_idle_valid"}, instr_valid, 32'h0);
         check({tag, "_idle_pc"},    current_pc,  32'h0);
         check({tag, "_idle_count"}, fetch_count, 32'h0);
         $display("program %s: reset after %0d cycles", tag, cycles);
         return;
      end

      #1;
      check({tag, "_end_done"},  done,        32'(!efault));
      check({tag, "_end_fault"}, fault,       32'(efault));
      check({tag, "_end_count"}, fetch_count, 32'(n));
      check({tag, "_end_pc"},    current_pc,  end_pc);
      check({tag, "_drained"},   exp_q.size(), 32'h0);
      exp_q.delete();
      $display("program %s: %0d instructions, %0d cycles, fault=%0b", tag, n, cycles, efault);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         check("pc_in_range", 32'(current_pc < 32'(DEPTH)), 32'h1);
         // An instruction is handed on when the consumer is not stalling, or
         // on the single cycle the last word of memory is shown before halt.
         if (!reset && instr_valid && (!stall || fault)) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_instr: got pc 0x%0h insn 0x%0h, expected none", instr_pc, instr_out);
            end else begin
               e = exp_q.pop_front();
               check("instr_pc", instr_pc, e.pc);
               check("instr_out", 32'(instr_out), 32'(e.insn));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      fill_plain();
      repeat (3) @(negedge clk);
      check("reset_pc",    current_pc,  32'h0);
      check("reset_insn",  instr_out,   32'h0);
      check("reset_ipc",   instr_pc,    32'h0);
      check("reset_valid", instr_valid, 32'h0);
      check("reset_done",  done,        32'h0);
      check("reset_fault", fault,       32'h0);
      check("reset_count", fetch_count, 32'h0);
      #1;
      reset = 1'b0;

      // Halt at PC 3, no stalls, latency checked.
      stall_en = 1'b0;
      prog_branch(1, 32'h2, 3);
      mem[1] = plain_insn();
      run_program("halt3", 1'b1, 0);
      stall_en = 1'b1;

      prog_branch(7, 32'h40, 32'h45);
      run_program("br40", 1'b0, 0);

      prog_branch(4, 32'h5, 8);
      run_program("br_next", 1'b0, 0);

      prog_branch(5, 32'd4096, -1);
      run_program("br4096", 1'b0, 0);

      prog_branch(9, 32'hFFFF_FFF0, -1);
      run_program("br_huge", 1'b0, 0);

      for (int k = 0; k < 6; k++) begin
         prog_random();
         run_program($sformatf("rand%0d", k), 1'b0, 0);
      end

      fill_plain();
      run_program("linear", 1'b0, 0);

      fill_plain();
      run_program("abort", 1'b0, 25);

      prog_branch(1, 32'h2, 2);
      mem[1] = plain_insn();
      run_program("after_rst", 1'b0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
